// File: rtl/gb_rd_ctrl_pkg.sv
// Shared definitions for the global-buffer bank controllers: state encodings,
// width defaults and the read-issue credit check.
package gb_rd_ctrl_pkg;

    localparam int unsigned SRAM_ADDRWIDTH_DEF = 9;
    localparam int unsigned DATA_WIDTH_DEF     = 96;
    localparam int unsigned CYCL_WIDTH_DEF     = 12;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'b00,
        WR_FILL  = 2'b01,
        WR_DONE  = 2'b11
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_EMPTY = 2'b00,
        RD_FULL  = 2'b01,
        RD_READ  = 2'b11
    } rd_state_e;

    // Words held or on their way (skid + in-flight read), less the one leaving now, must stay below 2.
    function automatic logic credit_ok(input logic [1:0] skid_cnt,
                                       input logic       inflight,
                                       input logic       pop);
        return ({1'b0, skid_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/gb_rd_skid.sv
// Two-entry valid/ready FIFO that catches SRAM read data arriving one cycle
// after the strobe; a flush empties it and drops any word pushed that cycle.
module gb_rd_skid #(
    parameter int unsigned DW = 96
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic          val_o,
    output logic [DW-1:0] data_o,
    output logic [1:0]    cnt_o
);

    logic [DW-1:0] mem_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;
    logic          do_pop_s;
    logic          do_push_s;

    // Handshake qualification and occupancy update.
    always_comb begin
        do_pop_s  = pop_i & (cnt_q != 2'd0);
        do_push_s = push_i & ((cnt_q != 2'd2) | do_pop_s);
        cnt_d     = cnt_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= {DW{1'b0}};
            mem_q[1] <= {DW{1'b0}};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign val_o  = (cnt_q != 2'd0);
    assign data_o = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/gb_rd_ctrl.sv
// Read-side controller for one global-buffer bank: once the bank is full it
// streams it CFGGB_Cycl_num times through a skid buffer and then frees it.
module gb_rd_ctrl
    import gb_rd_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_ADDRWIDTH = SRAM_ADDRWIDTH_DEF,
    parameter int unsigned SRAM_DEPTH     = 2 ** SRAM_ADDRWIDTH,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned CYCL_WIDTH     = CYCL_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      SRAM_config_start,
    input  logic                      write_SRAM_done,
    input  logic [CYCL_WIDTH-1:0]     CFGGB_Cycl_num,
    input  logic                      Rd_Req,
    output logic                      rd_en,
    output logic [SRAM_ADDRWIDTH-1:0] addr_Rd,
    input  logic [DATA_WIDTH-1:0]     sram_rd_data,
    output logic                      Rd_val,
    input  logic                      Rd_rdy,
    output logic [DATA_WIDTH-1:0]     Rd_data,
    output logic [1:0]                State_Rd,
    output logic                      bank_busy,
    output logic                      read_Cyc_done
);

    localparam logic [SRAM_ADDRWIDTH-1:0] LAST_ADDR = SRAM_ADDRWIDTH'(SRAM_DEPTH - 1);

    rd_state_e                 state_q, state_d;
    logic [SRAM_ADDRWIDTH-1:0] addr_q, addr_d;
    logic [CYCL_WIDTH-1:0]     pass_q, pass_d;
    logic                      issued_q, issued_d;
    logic                      inflight_q;
    logic [CYCL_WIDTH-1:0]     max_pass_s;
    logic [1:0]                skid_cnt_s;
    logic                      rd_val_s;
    logic                      pop_s;
    logic                      rd_en_s;
    logic                      last_pop_s;

    gb_rd_skid #(.DW(DATA_WIDTH)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (SRAM_config_start),
        .push_i      (inflight_q),
        .push_data_i (sram_rd_data),
        .pop_i       (Rd_rdy),
        .val_o       (rd_val_s),
        .data_o      (Rd_data),
        .cnt_o       (skid_cnt_s)
    );

    // FSM next state, read issue and address/pass counting.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        issued_d   = issued_q;
        rd_en_s    = 1'b0;
        max_pass_s = (CFGGB_Cycl_num == {CYCL_WIDTH{1'b0}}) ? {CYCL_WIDTH{1'b0}}
                                                            : CFGGB_Cycl_num - {{(CYCL_WIDTH-1){1'b0}}, 1'b1};
        pop_s      = rd_val_s & Rd_rdy;
        // The last word is the only one left once everything is issued and nothing is in flight.
        last_pop_s = (state_q == RD_READ) & issued_q & ~inflight_q & (skid_cnt_s == 2'd1)
                     & pop_s & ~SRAM_config_start;
        if (SRAM_config_start) begin
            state_d  = RD_EMPTY;
            addr_d   = {SRAM_ADDRWIDTH{1'b0}};
            pass_d   = {CYCL_WIDTH{1'b0}};
            issued_d = 1'b0;
        end else begin
            case (state_q)
                RD_EMPTY: begin
                    if (write_SRAM_done) state_d = RD_FULL;
                    else                 state_d = RD_EMPTY;
                end
                RD_FULL: begin
                    if (Rd_Req) state_d = RD_READ;
                    else        state_d = RD_FULL;
                end
                RD_READ: begin
                    rd_en_s = ~issued_q & credit_ok(skid_cnt_s, inflight_q, pop_s);
                    if (rd_en_s) begin
                        addr_d = addr_q + {{(SRAM_ADDRWIDTH-1){1'b0}}, 1'b1};
                        if (addr_q == LAST_ADDR) begin
                            pass_d = pass_q + {{(CYCL_WIDTH-1){1'b0}}, 1'b1};
                            if (pass_q == max_pass_s) issued_d = 1'b1;
                            else                      issued_d = issued_q;
                        end else begin
                            pass_d = pass_q;
                        end
                    end else begin
                        addr_d = addr_q;
                    end
                    if (last_pop_s) begin
                        state_d  = RD_EMPTY;
                        addr_d   = {SRAM_ADDRWIDTH{1'b0}};
                        pass_d   = {CYCL_WIDTH{1'b0}};
                        issued_d = 1'b0;
                    end else begin
                        state_d = RD_READ;
                    end
                end
                default: state_d = RD_EMPTY;
            endcase
        end
    end

    // State, counters and the one-cycle read-latency tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_EMPTY;
            addr_q     <= {SRAM_ADDRWIDTH{1'b0}};
            pass_q     <= {CYCL_WIDTH{1'b0}};
            issued_q   <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            issued_q   <= issued_d;
            inflight_q <= rd_en_s;
        end
    end

    assign rd_en         = rd_en_s;
    assign addr_Rd       = addr_q;
    assign Rd_val        = rd_val_s;
    assign State_Rd      = state_q;
    assign bank_busy     = (state_q != RD_EMPTY);
    assign read_Cyc_done = last_pop_s;

endmodule

// File: tb/tb_gb_rd_ctrl.sv
// Bench for gb_rd_ctrl on an 8-word bank whose SRAM returns its own address.
module tb_gb_rd_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int CW    = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg = 1'b0;
    logic          wdone = 1'b0;
    logic          req = 1'b0;
    logic          rdy = 1'b0;
    logic [CW-1:0] cycl = '0;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] sram_q = '0;
    logic [DW-1:0] rd_data;
    logic          rd_val;
    logic [1:0]    st;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int words_seen = 0;
    int exp_total = 0;
    int done_cnt = 0;
    int d0;
    logic          prev_stall = 1'b0;
    logic          prev_cfg = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    gb_rd_ctrl #(.SRAM_ADDRWIDTH(AW), .SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .CYCL_WIDTH(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .SRAM_config_start (cfg),
        .write_SRAM_done   (wdone),
        .CFGGB_Cycl_num    (cycl),
        .Rd_Req            (req),
        .rd_en             (rd_en),
        .addr_Rd           (addr),
        .sram_rd_data      (sram_q),
        .Rd_val            (rd_val),
        .Rd_rdy            (rdy),
        .Rd_data           (rd_data),
        .State_Rd          (st),
        .bank_busy         (busy),
        .read_Cyc_done     (done)
    );

    // SRAM model: one-cycle latency, word content equals its address.
    always @(posedge clk) begin
        if (rd_en) sram_q <= DW'(addr);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Stream model: the n-th accepted word must be n mod DEPTH; done only on word exp_total.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_vs_state", busy, st != 2'b00);
            chk("skid_bound", dut.u_skid.cnt_q <= 2'd2, 1'b1);
            if (prev_stall && !prev_cfg) begin
                chk("stall_valid", rd_val, 1'b1);
                chk("stall_hold", rd_data, prev_data);
            end
            if (rd_val && rdy) begin
                chk("data_order", rd_data, DW'(words_seen % DEPTH));
                words_seen++;
                chk("done_on_last", done, (words_seen == exp_total) && !cfg);
                if (done) done_cnt++;
            end else begin
                chk("done_idle", done, 1'b0);
            end
            prev_stall = rd_val && !rdy;
            prev_cfg   = cfg;
            prev_data  = rd_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_stream(input logic [CW-1:0] n, input int total);
        cycl       = n;
        exp_total  = total;
        words_seen = 0;
        wdone = 1'b1;
        @(posedge clk); #1;
        wdone = 1'b0;
        chk("state_full", st, 2'b01);
        req = 1'b1;
        @(negedge clk);
        chk("req_cycle_no_rd", rd_en, 1'b0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("read_state", st, 2'b11);
        chk("first_rd_en", rd_en, 1'b1);
        chk("first_addr", addr, 3'd0);
        @(negedge clk);
        chk("val_t2", rd_val, 1'b0);
        @(negedge clk);
        chk("val_t3", rd_val, 1'b1);
        chk("first_word", rd_data, 16'd0);
    endtask

    task automatic run_until_done(input int budget, input bit rand_rdy);
        int  start = done_cnt;
        bit  got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt != start) begin
                got = 1'b1;
                break;
            end
            if (rand_rdy) rdy = 1'($urandom_range(0, 1));
        end
        chk("done_seen", got, 1'b1);
        chk("empty_after_done", st, 2'b00);
        chk("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", st, 2'b00);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_addr", addr, 3'd0);
        chk("rst_val", rd_val, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single pass at full rate.
        rdy = 1'b1;
        d0 = done_cnt;
        start_stream(12'd1, 8);
        run_until_done(40, 1'b0);
        chk("t1_words", words_seen, 8);
        chk("t1_done_pulses", done_cnt - d0, 1);

        // Three passes, address wraps twice.
        d0 = done_cnt;
        start_stream(12'd3, 24);
        run_until_done(80, 1'b0);
        chk("t2_words", words_seen, 24);
        chk("t2_done_pulses", done_cnt - d0, 1);

        // Two passes with random back-pressure.
        d0 = done_cnt;
        start_stream(12'd2, 16);
        run_until_done(300, 1'b1);
        chk("t3_words", words_seen, 16);
        chk("t3_done_pulses", done_cnt - d0, 1);
        rdy = 1'b1;

        // Abort while word 4 of pass 0 is presented.
        start_stream(12'd1, 8);
        d0 = done_cnt;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (words_seen >= 4) break;
        end
        chk("t4_reached_word4", words_seen, 4);
        cfg = 1'b1;
        rdy = 1'b0;
        @(negedge clk);
        chk("t4_no_rd_en_in_abort", rd_en, 1'b0);
        @(posedge clk); #1;
        cfg = 1'b0;
        @(negedge clk);
        chk("t4_val", rd_val, 1'b0);
        chk("t4_state", st, 2'b00);
        chk("t4_addr", addr, 3'd0);
        chk("t4_done", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_done_pulse", done_cnt, d0);
        rdy = 1'b1;
        start_stream(12'd1, 8);
        run_until_done(40, 1'b0);
        chk("t4_restart_words", words_seen, 8);

        // Ignored events and Cycl_num=0 acting as 1.
        d0 = done_cnt;
        start_stream(12'd0, 8);
        @(posedge clk); #1;
        wdone = 1'b1;
        @(posedge clk); #1;
        wdone = 1'b0;
        chk("t5_wdone_in_read", st, 2'b11);
        run_until_done(40, 1'b0);
        chk("t5_words", words_seen, 8);
        chk("t5_done_pulses", done_cnt - d0, 1);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("t5_req_in_empty", st, 2'b00);

        // Asynchronous reset mid-stream.
        start_stream(12'd2, 16);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_state", st, 2'b00);
        chk("t6_rd_en", rd_en, 1'b0);
        chk("t6_addr", addr, 3'd0);
        chk("t6_val", rd_val, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_idle_after", st, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
